// File: rtl/sample_monitor.sv
// sample_monitor: samples in_data on rising clk edges, stamps each captured
// sample with the free-running cycle counter and queues {data, ts} in a
// first-word-fall-through FIFO that a downstream checker drains via
// out_valid/out_ready.
module sample_monitor #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int TS_W        = 16,
  parameter int CHANGE_ONLY = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [TS_W-1:0]            out_ts,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Sample storage (data path, never reset)
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [TS_W-1:0]   mem_ts   [DEPTH];

  // Control state
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [TS_W-1:0]   ts;
  logic              primed;
  logic [DATA_W-1:0] last;
  logic              ovf_q;
  logic [7:0]        drop_q;

  // Registered FIFO head presented to the consumer
  logic [DATA_W-1:0] head_data;
  logic [TS_W-1:0]   head_ts;

  logic              qual;
  logic              is_full;
  logic              is_empty;
  logic              do_pop;
  logic              do_push;
  logic              do_drop;
  logic [PTR_W-1:0]  nxt_rd_ptr;

  // Per-edge decisions: qualification, push/pop/drop
  always_comb begin
    qual       = in_valid & ((CHANGE_ONLY == 0) | ~primed | (in_data != last));
    is_full    = (cnt == CNT_W'(DEPTH));
    is_empty   = (cnt == '0);
    do_pop     = ~is_empty & out_ready;
    do_push    = qual & (~is_full | do_pop);
    do_drop    = qual & is_full & ~do_pop;
    nxt_rd_ptr = rd_ptr + 1'b1;
  end

  // All sequential state: timestamp, FIFO, head register, drop accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      ts        <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      primed    <= 1'b0;
      last      <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
      head_data <= '0;
      head_ts   <= '0;
    end else begin
      // The counter free-runs through clear; captures use the pre-edge value.
      ts <= ts + 1'b1;
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
        primed <= 1'b0;
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end else begin
        if (qual) begin
          last   <= in_data;
          primed <= 1'b1;
        end
        if (do_push) begin
          mem_data[wr_ptr] <= in_data;
          mem_ts[wr_ptr]   <= ts;
          wr_ptr           <= wr_ptr + 1'b1;
        end
        if (do_pop) begin
          rd_ptr <= nxt_rd_ptr;
        end
        cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        // Head refresh: the next stored entry after a pop, or the incoming
        // sample when it becomes the only entry (fall-through).
        if (do_pop) begin
          if (cnt > CNT_W'(1)) begin
            head_data <= mem_data[nxt_rd_ptr];
            head_ts   <= mem_ts[nxt_rd_ptr];
          end else if (do_push) begin
            head_data <= in_data;
            head_ts   <= ts;
          end
        end else if (is_empty && do_push) begin
          head_data <= in_data;
          head_ts   <= ts;
        end
        if (do_drop) begin
          ovf_q <= 1'b1;
          if (drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
          end
        end
      end
    end
  end

  assign out_valid = (cnt != '0);
  assign out_data  = head_data;
  assign out_ts    = head_ts;
  assign count     = cnt;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_sample_monitor.sv
// tb_sample_monitor: two sample_monitor instances (default parameters, and a
// small change-only variant with a 4-bit timestamp) share randomized stimulus
// and are compared every cycle against a queue-based reference model.
module tb_sample_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;

  logic       ov0, ovf0;
  logic [7:0] od0, dc0;
  logic [15:0] ots0;
  logic [3:0] cnt0;

  logic       ov1, ovf1;
  logic [7:0] od1, dc1;
  logic [3:0] ots1;
  logic [2:0] cnt1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sample_monitor #(.DATA_W(8), .DEPTH(8), .TS_W(16), .CHANGE_ONLY(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .clear(clear),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ts(ots0),
    .count(cnt0), .overflow(ovf0), .drop_cnt(dc0)
  );

  sample_monitor #(.DATA_W(8), .DEPTH(4), .TS_W(4), .CHANGE_ONLY(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .clear(clear),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ts(ots1),
    .count(cnt1), .overflow(ovf1), .drop_cnt(dc1)
  );

  // Reference model: per-instance queues of {ts, data} plus scalar state
  int q0[$];
  int q1[$];
  int m_ts[2];
  int m_primed[2];
  int m_last[2];
  int m_ovf[2];
  int m_drop[2];
  int m_hd[2];
  int m_ht[2];

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int k, input int v);
    if (k == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic qpop(input int k);
    int d;
    if (k == 0) d = q0.pop_front(); else d = q1.pop_front();
  endtask

  task automatic qclear(input int k);
    if (k == 0) q0.delete(); else q1.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Applies one rising edge to instance k's model using the current inputs.
  task automatic model_step(input int k);
    int  depth, tsmod, sz, v;
    bit  qual, pop;
    depth = (k == 0) ? 8 : 4;
    tsmod = (k == 0) ? 65536 : 16;
    if (rst) begin
      m_ts[k] = 0; m_primed[k] = 0; m_last[k] = 0;
      m_ovf[k] = 0; m_drop[k] = 0; m_hd[k] = 0; m_ht[k] = 0;
      qclear(k);
      return;
    end
    qual = in_valid && ((k == 0) || (m_primed[k] == 0) || (int'(in_data) != m_last[k]));
    sz   = qsize(k);
    pop  = (sz > 0) && out_ready;
    if (clear) begin
      qclear(k);
      m_ovf[k] = 0; m_drop[k] = 0; m_primed[k] = 0;
    end else begin
      if (qual) begin
        m_last[k] = int'(in_data);
        m_primed[k] = 1;
      end
      if (pop) qpop(k);
      if (qual) begin
        if (sz < depth || pop) begin
          qpush(k, (m_ts[k] << 8) | int'(in_data));
        end else begin
          m_ovf[k] = 1;
          if (m_drop[k] < 255) m_drop[k]++;
        end
      end
    end
    m_ts[k] = (m_ts[k] + 1) % tsmod;
    if (qsize(k) > 0) begin
      v = qfront(k);
      m_hd[k] = v & 255;
      m_ht[k] = v >>> 8;
    end
  endtask

  task automatic check_all();
    check("valid0", 32'(ov0), 32'(qsize(0) > 0));
    check("data0",  32'(od0), 32'(m_hd[0]));
    check("ts0",    32'(ots0), 32'(m_ht[0]));
    check("count0", 32'(cnt0), 32'(qsize(0)));
    check("ovf0",   32'(ovf0), 32'(m_ovf[0]));
    check("drop0",  32'(dc0), 32'(m_drop[0]));
    check("valid1", 32'(ov1), 32'(qsize(1) > 0));
    check("data1",  32'(od1), 32'(m_hd[1]));
    check("ts1",    32'(ots1), 32'(m_ht[1]));
    check("count1", 32'(cnt1), 32'(qsize(1)));
    check("ovf1",   32'(ovf1), 32'(m_ovf[1]));
    check("drop1",  32'(dc1), 32'(m_drop[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    tick();
    tick();
    check("rst_count0", 32'(cnt0), 32'd0);
    check("rst_ts0", 32'(ots0), 32'd0);
    rst = 1'b0;

    // Ordered capture with immediate drain
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 8'd1; tick();
    in_data = 8'd2; tick();
    in_valid = 1'b0; tick(); tick();

    // Fill past capacity with the consumer stalled
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'h10 + 8'(i);
      tick();
    end
    check("fill_count0", 32'(cnt0), 32'd8);
    check("fill_drop0", 32'(dc0), 32'd2);
    check("fill_head0", 32'(od0), 32'h10);
    check("fill_drop1", 32'(dc1), 32'd6);

    // Full FIFO with simultaneous push and pop
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h20 + 8'(i);
      tick();
    end
    check("fullpp_count0", 32'(cnt0), 32'd8);
    check("fullpp_drop0", 32'(dc0), 32'd2);

    // Clear with a qualified sample present at the same edge
    out_ready = 1'b0; clear = 1'b1; in_data = 8'h23;
    tick();
    clear = 1'b0;
    check("clr_count0", 32'(cnt0), 32'd0);
    check("clr_ovf0", 32'(ovf0), 32'd0);
    // Same value again must still be captured by the change-only instance
    tick();
    check("clr_recap1", 32'(cnt1), 32'd1);
    in_valid = 1'b0;
    tick();

    // Saturate drop_cnt with the consumer stalled
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_data = 8'(i);
      tick();
    end
    check("sat_drop0", 32'(dc0), 32'd255);
    check("sat_drop1", 32'(dc1), 32'd255);

    // Randomized phases with varying load, back-pressure, clear and reset
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 400; i++) begin
        in_valid  = ($urandom_range(0, 99) < 20 + p * 15);
        out_ready = ($urandom_range(0, 99) < 90 - p * 15);
        in_data   = (p[0]) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
        clear     = ($urandom_range(0, 199) == 0);
        rst       = ($urandom_range(0, 399) == 0);
        tick();
      end
    end
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sample_monitor.md
Name: sample_monitor

Overview:
- Synchronous sampling-side counterpart to the team's stimulus drivers: captures an input bus on rising clk edges, tags each sample with a cycle timestamp, and buffers the tagged samples in a FWFT FIFO.
- A downstream checker drains the FIFO through a valid/ready handshake.
- Lets benches verify that data driven mid-cycle is observed at the following edge, with exact cycle stamps.

Parameters:
- DATA_W, 8, width of sampled bus.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- TS_W, 16, timestamp counter width.
- CHANGE_ONLY, 0, 1 = capture only when in_data differs from the last captured value.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  bus being sampled.
- in_valid  in  1  sample qualifier.
- clear  in  1  synchronous flush of FIFO, overflow, drop_cnt; timestamp keeps running.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  DATA_W  head sample data.
- out_ts  out  TS_W  head sample timestamp.
- count  out  $clog2(DEPTH)+1  entries held.
- overflow  out  1  sticky: a qualified sample was dropped.
- drop_cnt  out  8  dropped samples, saturates at 255.

Behaviour:
- Reset (rst=1 at edge): ts=0, FIFO empty, out_valid=0, out_data=0, out_ts=0, count=0, overflow=0, drop_cnt=0, primed=0, last=0. rst has priority over every other input.
- Timestamp: ts increments by 1 every edge after reset; wraps 2^TS_W-1 -> 0 with no flag. A sample captured at edge E carries the ts value in effect before edge E. The first edge after reset release stamps 0.
- Qualified sample: in_valid=1 AND (CHANGE_ONLY=0 OR primed=0 OR in_data!=last).
  - last<=in_data and primed<=1 on every qualified sample, whether it is accepted or dropped.
- Push: a qualified sample at edge E is written at E. With FWFT, if the FIFO was empty, out_valid=1 and out_data/out_ts show that sample immediately after E (latency 1 edge from sampled input to visible output).
- Pop: when out_valid & out_ready at an edge, the head is removed and the next entry is presented after that edge. out_data/out_ts hold their value while out_valid=0 (last head or reset value; don't-care to consumer).
- Full (count==DEPTH):
  - Qualified sample with no pop at the same edge: dropped, overflow<=1, drop_cnt += 1 (saturating).
  - Push and pop at the same edge: both accepted, count unchanged, no drop.
- Empty: out_ready ignored. A push while empty is not poppable in the same edge.
- Simultaneous push+pop, non-empty, non-full: count unchanged, order preserved.
- clear=1 (rst=0): FIFO emptied, count=0, out_valid=0, overflow=0, drop_cnt=0, primed=0. A qualified sample at the same edge is discarded and not counted as a drop. ts unaffected.
- Pointers: log2(DEPTH)-bit read/write pointers that wrap naturally. count is tracked separately; full and empty derive from count.
- rst or clear mid-drain: any in-flight head is lost; no partial outputs.
- Implementation: single always_ff block for state, all outputs registered or derived directly from registers, no latches.

Test Plan:
1. Reset, then drive in_data=1 at 2 time units after edge 1 and in_data=2 after edge 2, in_valid=1, out_ready=1 -> entries popped in order: data 1 with ts 1, data 2 with ts 2; each appears on the output 1 edge after sampling.
2. DEPTH=8, out_ready=0, 10 consecutive qualified samples 0x10..0x19 -> count=8, overflow=1, drop_cnt=2; draining yields 0x10..0x17 in order.
3. Full FIFO with out_ready=1 and in_valid=1 for 4 edges -> count stays 8, drop_cnt unchanged, output order continuous.
4. CHANGE_ONLY=1, in_data sequence 5,5,5,7,7,5 with in_valid=1 -> captured data 5, 7, 5 with ts matching the first edge of each run.
5. TS_W=4: run 20 edges, then sample -> out_ts = 4 (wrapped from 15 to 0).
6. Half-full FIFO with overflow=1, assert clear for 1 edge with in_valid=1 -> count=0, out_valid=0, overflow=0, drop_cnt=0; next sample is captured even if it equals the previous data (primed cleared); ts is continuous across the clear.
